// File: rtl/conv_result_writer_if.sv
// Result-stream and output-memory handshake bundle for conv_result_writer.
// The master view is the writer itself; the slave view is its environment.
interface conv_result_writer_if #(
    parameter int ADDR_W = 18
);
    logic                    res_valid;
    logic signed [15:0]      res_data;
    logic                    res_ready;

    logic                    mem_we;
    logic [ADDR_W-1:0]       mem_addr;
    logic [7:0]              mem_din;
    logic                    mem_ack;

    modport master (
        input  res_valid, res_data, mem_ack,
        output res_ready, mem_we, mem_addr, mem_din
    );

    modport slave (
        output res_valid, res_data, mem_ack,
        input  res_ready, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/conv_result_writer.sv
// Saturates signed 16-bit convolution results to 8-bit pixels and writes one
// (IMG_W-2)x(IMG_H-2) frame per start to the output memory through a 2-entry FIFO.
module conv_result_writer #(
    parameter int IMG_W  = 512,
    parameter int IMG_H  = 512,
    parameter int ADDR_W = 18
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    conv_result_writer_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          sat_cnt
);

    localparam int                TOTAL     = (IMG_W - 2) * (IMG_H - 2);
    localparam int                CNT_W     = $clog2(TOTAL + 1);
    localparam logic [CNT_W-1:0]  TOTAL_CNT = CNT_W'(TOTAL);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t            state;
    logic [7:0]        fifo_q [2];
    logic              rd_ptr;
    logic [1:0]        fifo_count;
    logic [CNT_W-1:0]  accepted;
    logic [ADDR_W-1:0] wr_addr;

    logic              push;
    logic              pop;
    logic              wr_ptr;
    logic              clipped;
    logic [7:0]        pixel;

    // Handshake outputs decode registered state only, so res_ready never
    // combinationally depends on mem_ack or res_valid.
    assign bus.res_ready = (state == ST_RUN) && (fifo_count < 2'd2) && (accepted < TOTAL_CNT);
    assign bus.mem_we    = (state == ST_RUN) && (fifo_count != 2'd0);
    assign bus.mem_addr  = wr_addr;
    assign bus.mem_din   = fifo_q[rd_ptr];

    assign push   = bus.res_valid && bus.res_ready;
    assign pop    = bus.mem_we && bus.mem_ack;
    // With one entry queued the new result lands behind the head, even when the head pops.
    assign wr_ptr = rd_ptr ^ fifo_count[0];

    // NOTE: every output of a combinational block gets a default first; a path
    // that leaves one unassigned infers a latch.
    always_comb begin
        pixel   = bus.res_data[7:0];
        clipped = 1'b0;
        if (bus.res_data[15]) begin
            pixel   = 8'h00;
            clipped = 1'b1;
        end else if (|bus.res_data[14:8]) begin
            pixel   = 8'hFF;
            clipped = 1'b1;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            sat_cnt    <= 16'd0;
            accepted   <= '0;
            wr_addr    <= '0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
            // NOTE: the two FIFO slots are reset because the head drives mem_din
            // directly; a large RAM would normally be left unreset.
            fifo_q[0]  <= 8'h00;
            fifo_q[1]  <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_RUN;
                        busy       <= 1'b1;
                        sat_cnt    <= 16'd0;
                        accepted   <= '0;
                        wr_addr    <= '0;
                        rd_ptr     <= 1'b0;
                        fifo_count <= 2'd0;
                    end
                end

                ST_RUN: begin
                    if (push) begin
                        fifo_q[wr_ptr] <= pixel;
                        accepted       <= accepted + CNT_W'(1);
                        if (clipped && (sat_cnt != 16'hFFFF)) begin
                            sat_cnt <= sat_cnt + 16'd1;
                        end
                    end
                    if (pop) begin
                        rd_ptr <= ~rd_ptr;
                        // The address parks on the last pixel rather than wrapping.
                        if (wr_addr == LAST_ADDR) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            wr_addr <= wr_addr + ADDR_W'(1);
                        end
                    end
                    fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    a_fifo_bound: assert property (@(posedge clk) disable iff (!rst)
        fifo_count <= 2'd2);

    a_write_hold: assert property (@(posedge clk) disable iff (!rst)
        (bus.mem_we && !bus.mem_ack) |=>
            (bus.mem_we && $stable(bus.mem_addr) && $stable(bus.mem_din)));

    a_no_overrun: assert property (@(posedge clk) disable iff (!rst)
        (accepted == TOTAL_CNT) |-> !bus.res_ready);

endmodule
